mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (imem/dmem) arbiter onto one downstream memory port, one transaction in flight, dmem-priority with starvation limit.
// Optional MEM_ARB_ERR_EN: malformed requests answered locally with err=1 instead of being forwarded.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_imem_req,
  input  logic [31:0] i_imem_addr,
  output logic        o_imem_ready,
  output logic        o_imem_rvalid,
  output logic [31:0] o_imem_rdata,
  output logic        o_imem_err,
  input  logic        i_dmem_req,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_ready,
  output logic        o_dmem_rvalid,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_err,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  mask_q;
  logic        ren_q, wen_q, gnt_d_q;
  logic        gnt_d, gnt_i, req_bad, resp;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_d     = 1'b0;
    gnt_i     = 1'b0;
    req_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (i_dmem_req && (!i_imem_req || starve_cnt < 4'(STARVE_LIMIT))) gnt_d = 1'b1;
        else if (i_imem_req)                                               gnt_i = 1'b1;
`ifdef MEM_ARB_ERR_EN
        if (gnt_d)      req_bad = (i_dmem_ren == i_dmem_wen) || (i_dmem_mask == 4'b0000);
        else if (gnt_i) req_bad = (i_imem_addr[1:0] != 2'b00);
`endif
        if (gnt_d || gnt_i) state_nxt = req_bad ? RESP : ISSUE;
      end
      ISSUE:   if (i_mem_ready) state_nxt = WAIT;
      WAIT:    if (i_mem_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mask_q     <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      gnt_d_q    <= 1'b0;
    end else begin
      if (gnt_d) begin
        addr_q  <= i_dmem_addr;
        ren_q   <= i_dmem_ren;
        wen_q   <= i_dmem_wen;
        wdata_q <= i_dmem_wdata;
        mask_q  <= i_dmem_mask;
        gnt_d_q <= 1'b1;
      end else if (gnt_i) begin
        addr_q  <= i_imem_addr;
        ren_q   <= 1'b1;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        mask_q  <= 4'b1111;
        gnt_d_q <= 1'b0;
      end
      if (state == IDLE) begin
        if (gnt_i || !i_imem_req)             starve_cnt <= '0;
        else if (gnt_d && starve_cnt != 4'hf) starve_cnt <= starve_cnt + 4'd1;
      end
      // Error responses carry rdata 0; normal ones take the downstream word.
      if (gnt_d || gnt_i)                      rdata_q <= '0;
      else if (state == WAIT && i_mem_valid)   rdata_q <= i_mem_rdata;
    end
  end

`ifdef MEM_ARB_ERR_EN
  logic err_q;
  always_ff @(posedge i_clk) begin
    if (i_rst)               err_q <= 1'b0;
    else if (gnt_d || gnt_i) err_q <= req_bad;
  end
  assign o_imem_err = o_imem_rvalid & err_q;
  assign o_dmem_err = o_dmem_rvalid & err_q;
`else
  assign o_imem_err = 1'b0;
  assign o_dmem_err = 1'b0;
`endif

  assign resp          = (state == RESP) && !i_rst;
  assign o_imem_ready  = gnt_i && !i_rst;
  assign o_dmem_ready  = gnt_d && !i_rst;
  assign o_imem_rvalid = resp && !gnt_d_q;
  assign o_dmem_rvalid = resp && gnt_d_q;
  assign o_imem_rdata  = o_imem_rvalid ? rdata_q : '0;
  assign o_dmem_rdata  = o_dmem_rvalid ? rdata_q : '0;

  assign o_mem_req   = (state == ISSUE) && !i_rst;
  assign o_mem_addr  = {addr_q[31:2], addr_q[1:0] & 2'b00};
  assign o_mem_ren   = ren_q;
  // A read+write dmem request is forwarded as a read so ren/wen are never both high.
  assign o_mem_wen   = wen_q && !ren_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_mask  = mask_q;

endmodule
